fpu_mul_arbiter: RTL

FPU_MUL_ARBITER -- requirements
Module: fpu_mul_arbiter

---
 rtl/fpu_pkg.sv | 16 +
 rtl/mul.sv | 72 +++++++
 rtl/fpu_mul_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FP16 multiplier arbiter.
//   FP_W    : FP16 operand/result width
//   CNT_W   : width of the calculation-cycle down-counter (CALC_CYCLES <= 15)
//   state_t : arbiter FSM state encoding
package fpu_pkg;

    localparam int FP_W  = 16;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mul.sv
// Combinational FP16 multiplier.
//   a, b  : FP16 operands
//   p     : FP16 product, round-to-nearest-even
//   valid : low when the result is NaN (NaN operand, or infinity times zero)
// Subnormal operands are treated as zero and results that would be subnormal
// flush to a signed zero; NaN results use the canonical quiet NaN 0x7E00.
module mul
    import fpu_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] p,
    output logic            valid
);

    logic        sign;
    logic [4:0]  ea;
    logic [4:0]  eb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [21:0] sig_a, sig_b, prod;
    logic        norm;
    logic [9:0]  mant;
    logic        guard, sticky, round_up;
    logic [10:0] mant_r;
    logic [7:0]  exp_t;
    logic [4:0]  exp_b;

    assign sign  = a[15] ^ b[15];
    assign ea    = a[14:10];
    assign eb    = b[14:10];
    assign sig_a = {11'd0, 1'b1, a[9:0]};
    assign sig_b = {11'd0, 1'b1, b[9:0]};
    assign prod  = sig_a * sig_b;

    always_comb begin
        a_zero = (ea == 5'd0);
        b_zero = (eb == 5'd0);
        a_inf  = (ea == 5'h1f) && (a[9:0] == 10'd0);
        b_inf  = (eb == 5'h1f) && (b[9:0] == 10'd0);
        a_nan  = (ea == 5'h1f) && (a[9:0] != 10'd0);
        b_nan  = (eb == 5'h1f) && (b[9:0] != 10'd0);

        // Significand product lies in [1,4); bit 21 set means it is in [2,4).
        norm     = prod[21];
        mant     = norm ? prod[20:11] : prod[19:10];
        guard    = norm ? prod[10] : prod[9];
        sticky   = norm ? |prod[9:0] : |prod[8:0];
        round_up = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + {10'd0, round_up};

        // Biased result exponent plus 15; carry out of rounding bumps it.
        exp_t = {3'd0, ea} + {3'd0, eb} + {7'd0, norm} + {7'd0, mant_r[10]};
        exp_b = exp_t[4:0] - 5'd15;

        valid = 1'b1;
        p     = {sign, exp_b, mant_r[9:0]};

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            valid = 1'b0;
            p     = 16'h7E00;
        end else if (a_inf || b_inf) begin
            p = {sign, 5'h1f, 10'd0};
        end else if (a_zero || b_zero) begin
            p = {sign, 15'd0};
        end else if (exp_t < 8'd16) begin
            p = {sign, 15'd0};
        end else if (exp_t > 8'd45) begin
            p = {sign, 5'h1f, 10'd0};
        end
    end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Two-requester round-robin arbiter in front of a shared FP16 multiplier.
//   clock, reset        : rising-edge clock, async active-high reset
//   req_valid/req_ready : per-requester handshake (bit i = requester i)
//   req0_a/b, req1_a/b  : FP16 operand pairs
//   rsp_valid/rsp_ready : response handshake
//   rsp_data            : FP16 product
//   rsp_id              : requester that owns the response
//   rsp_invalid         : product is NaN
//   busy                : an operation is in flight
// CALC_CYCLES (1..15) is how long registered operands sit at the multiplier
// before the product is captured.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a request; grants one requester combinationally
// CALC  | registered operands at the multiplier, counter running down
// RESP  | response held until rsp_ready
module fpu_mul_arbiter
    import fpu_pkg::*;
#(
    parameter int CALC_CYCLES = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [FP_W-1:0] req0_a,
    input  logic [FP_W-1:0] req0_b,
    input  logic [FP_W-1:0] req1_a,
    input  logic [FP_W-1:0] req1_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [FP_W-1:0] rsp_data,
    output logic            rsp_id,
    output logic            rsp_invalid,
    output logic            busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CALC_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last_grant;
    logic [FP_W-1:0]   op_a;
    logic [FP_W-1:0]   op_b;
    logic              op_id;
    logic              grant_id;
    logic              accept;
    logic [FP_W-1:0]   mul_p;
    logic              mul_valid;

    // With both requesters valid the one not granted last wins.
    always_comb begin
        grant_id  = (&req_valid) ? ~last_grant : req_valid[1];
        req_ready = 2'b00;
        if (state == IDLE && (|req_valid) && !reset)
            req_ready = grant_id ? 2'b10 : 2'b01;
        accept = |(req_valid & req_ready);
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    mul u_mul (
        .a     (op_a),
        .b     (op_b),
        .p     (mul_p),
        .valid (mul_valid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= 1'b1;
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= 1'b0;
            rsp_data    <= '0;
            rsp_id      <= 1'b0;
            rsp_invalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a       <= grant_id ? req1_a : req0_a;
                        op_b       <= grant_id ? req1_b : req0_b;
                        op_id      <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= CNT_LOAD;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    if (cnt == '0) begin
                        rsp_data    <= mul_p;
                        rsp_id      <= op_id;
                        rsp_invalid <= ~mul_valid;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
